// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and timing defaults for the DHT11 receiver.
// Holds the receiver state enum, the frame length and a checksum helper.
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FALL,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } state_t;

   localparam int FRAME_BITS        = 40;
   localparam int DEF_CLK_PER_US    = 1;
   localparam int DEF_BIT_THRESH_US = 40;
   localparam int DEF_TIMEOUT_US    = 120;

   // Sum of the four data bytes modulo 256 must equal the last byte.
   function automatic logic frame_ok(
      input logic [FRAME_BITS-1:0] f
   );
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return (s == f[7:0]);
   endfunction

endpackage

// File: rtl/dht_line_sync.sv
// dht_line_sync: 2-FF synchronizer for the DHT11 data line plus edge strobes.
// Ports: clk, rst (async active-low), dht_in (raw line), rise/fall (1-cycle).
module dht_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic dht_in,
   output logic rise,
   output logic fall
);

   logic meta;
   logic line;
   logic line_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta   <= 1'b0;
         line   <= 1'b0;
         line_q <= 1'b0;
      end else begin
         meta   <= dht_in;
         line   <= meta;
         line_q <= line;
      end
   end

   assign rise = line & ~line_q;
   assign fall = ~line & line_q;

endmodule

// File: rtl/dht11_receiver.sv
// dht11_receiver: decodes the 40-bit DHT11 frame after the start stage
// confirms the sensor response, checks the checksum and reports errors.
// Ports: clk, rst (async active-low), start (level), dht_in (raw line),
// hum_int/hum_dec/temp_int/temp_dec (bytes), data_valid, checksum_err,
// timeout_err (1-cycle pulses), busy (high outside IDLE).
module dht11_receiver
   import dht11_pkg::*;
#(
   parameter int CLK_PER_US    = DEF_CLK_PER_US,
   parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
   parameter int TIMEOUT_US    = DEF_TIMEOUT_US
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dht_in,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec,
   output logic       data_valid,
   output logic       checksum_err,
   output logic       timeout_err,
   output logic       busy
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam int CW = $clog2(TIMEOUT_US + 2);
   localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

   state_t state;
   state_t state_nx;

   logic rise;
   logic fall;
   logic start_q;
   logic start_rise;

   logic [PW-1:0] pre_q;
   logic [CW-1:0] us_q;
   logic [CW-1:0] us_inc;
   logic tick;
   logic tmo;
   logic bit_val;

   logic [5:0] bit_q;
   logic [FRAME_BITS-1:0] sh_q;

   logic clr;
   logic shift_en;
   logic dv_nx;
   logic ck_nx;
   logic to_nx;

   dht_line_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .dht_in (dht_in),
      .rise   (rise),
      .fall   (fall)
   );

   assign start_rise = start & ~start_q;
   assign tick       = (pre_q == PW'(CLK_PER_US - 1));

   // Count including the microsecond that ends in this cycle, so a
   // pulse of N us reads N on the cycle its closing edge is seen.
   assign us_inc  = us_q + CW'(tick);
   assign tmo     = (us_inc > CW'(TIMEOUT_US));
   assign bit_val = (us_inc > CW'(BIT_THRESH_US));

   assign busy = (state != IDLE);

   always_comb begin
      state_nx = state;
      clr      = 1'b0;
      shift_en = 1'b0;
      dv_nx    = 1'b0;
      ck_nx    = 1'b0;
      to_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_rise) begin
               state_nx = WAIT_FALL;
               clr      = 1'b1;
            end
         end
         WAIT_FALL: begin
            if (tmo) begin
               state_nx = IDLE;
               to_nx    = 1'b1;
            end else if (fall) begin
               state_nx = BIT_LOW;
               clr      = 1'b1;
            end
         end
         BIT_LOW: begin
            if (tmo) begin
               state_nx = IDLE;
               to_nx    = 1'b1;
            end else if (rise) begin
               state_nx = BIT_HIGH;
               clr      = 1'b1;
            end
         end
         BIT_HIGH: begin
            if (tmo) begin
               state_nx = IDLE;
               to_nx    = 1'b1;
            end else if (fall) begin
               shift_en = 1'b1;
               clr      = 1'b1;
               state_nx = (bit_q == LAST_BIT) ? CHECK : BIT_LOW;
            end
         end
         CHECK: begin
            state_nx = IDLE;
            if (frame_ok(sh_q)) dv_nx = 1'b1;
            else                ck_nx = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // start_q comes out of reset high: a start level held across reset
   // is not an edge, so the block waits for a fresh one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_q <= 1'b1;
      end else begin
         start_q <= start;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
         us_q  <= '0;
      end else if (clr || state == IDLE) begin
         pre_q <= '0;
         us_q  <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + PW'(1);
         us_q  <= us_inc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_q <= '0;
         sh_q  <= '0;
      end else if (state == IDLE) begin
         bit_q <= '0;
         sh_q  <= '0;
      end else if (shift_en) begin
         bit_q <= (bit_q == LAST_BIT) ? bit_q : bit_q + 6'd1;
         sh_q  <= {sh_q[FRAME_BITS-2:0], bit_val};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_valid   <= 1'b0;
         checksum_err <= 1'b0;
         timeout_err  <= 1'b0;
         hum_int      <= '0;
         hum_dec      <= '0;
         temp_int     <= '0;
         temp_dec     <= '0;
      end else begin
         data_valid   <= dv_nx;
         checksum_err <= ck_nx;
         timeout_err  <= to_nx;
         if (dv_nx) begin
            hum_int  <= sh_q[39:32];
            hum_dec  <= sh_q[31:24];
            temp_int <= sh_q[23:16];
            temp_dec <= sh_q[15:8];
         end
      end
   end

endmodule

// File: tb/tb_dht11_receiver.sv
// tb_dht11_receiver: randomized self-checking bench for dht11_receiver.
// One clk cycle is one microsecond (CLK_PER_US = 1).
`timescale 1ns/1ps
module tb_dht11_receiver;

   localparam int PERIOD = 10;
   localparam int THRESH = 40;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic dht_in;
   logic [7:0] hum_int;
   logic [7:0] hum_dec;
   logic [7:0] temp_int;
   logic [7:0] temp_dec;
   logic data_valid;
   logic checksum_err;
   logic timeout_err;
   logic busy;

   dht11_receiver #(
      .CLK_PER_US    (1),
      .BIT_THRESH_US (THRESH),
      .TIMEOUT_US    (120)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dht_in       (dht_in),
      .hum_int      (hum_int),
      .hum_dec      (hum_dec),
      .temp_int     (temp_int),
      .temp_dec     (temp_dec),
      .data_valid   (data_valid),
      .checksum_err (checksum_err),
      .timeout_err  (timeout_err),
      .busy         (busy)
   );

   always #(PERIOD/2) clk = ~clk;

   int total  = 0;
   int passed = 0;

   int dv_n   = 0;
   int ck_n   = 0;
   int to_n   = 0;
   int excl_n = 0;
   time dv_t  = 0;
   time to_t  = 0;
   time fall_t = 0;
   time low_t  = 0;

   int widths[40];
   int lows[40];
   int restart_at = -1;
   logic [31:0] exp_out = '0;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dv_n++;
         dv_t = $time;
      end
      if (checksum_err === 1'b1) ck_n++;
      if (timeout_err === 1'b1) begin
         to_n++;
         to_t = $time;
      end
      if ($countones({data_valid, checksum_err, timeout_err}) > 1)
         excl_n++;
   end

   function automatic logic [31:0] outs();
      return {hum_int, hum_dec, temp_int, temp_dec};
   endfunction

   // Reference: a high pulse longer than the threshold is a 1, MSB first.
   function automatic logic [39:0] model_word();
      logic [39:0] w;
      for (int i = 0; i < 40; i++) w[39-i] = (widths[i] > THRESH);
      return w;
   endfunction

   function automatic bit model_good(input logic [39:0] w);
      int s;
      s = int'(w[39:32]) + int'(w[31:24]) + int'(w[23:16]) + int'(w[15:8]);
      return (s % 256) == int'(w[7:0]);
   endfunction

   function automatic logic [39:0] rand_frame(input bit corrupt);
      logic [7:0] b[5];
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         b[i] = 8'($urandom_range(255));
         s += int'(b[i]);
      end
      b[4] = 8'(s % 256);
      if (corrupt) b[4] = b[4] ^ 8'($urandom_range(255, 1));
      return {b[0], b[1], b[2], b[3], b[4]};
   endfunction

   // mode 0: random widths, 1: 50/27/70 nominal, 2: 40/41 boundary
   task automatic set_widths(input logic [39:0] f, input int mode);
      for (int i = 0; i < 40; i++) begin
         case (mode)
            1: begin
               lows[i]   = 50;
               widths[i] = f[39-i] ? 70 : 27;
            end
            2: begin
               lows[i]   = $urandom_range(30, 20);
               widths[i] = f[39-i] ? 41 : 40;
            end
            default: begin
               lows[i]   = $urandom_range(55, 20);
               widths[i] = f[39-i] ? $urandom_range(75, 41)
                                   : $urandom_range(40, 15);
            end
         endcase
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      dht_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int nbits);
      start = 1'b0;
      drive(1'b1, 3);
      start = 1'b1;
      drive(1'b1, 40);
      for (int i = 0; i < nbits; i++) begin
         low_t = $time;
         if (i == restart_at) begin
            dht_in = 1'b0;
            repeat (5) @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
            repeat (lows[i] - 6) @(negedge clk);
         end else begin
            drive(1'b0, lows[i]);
         end
         drive(1'b1, widths[i]);
      end
      if (nbits == 40) begin
         fall_t = $time;
         drive(1'b0, 50);
         drive(1'b1, 20);
      end
   endtask

   task automatic test_reset();
      total++;
      if (outs() !== 32'h0)
         $display("FAIL reset_bytes: got %h want 00000000", outs());
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else passed++;
      total++;
      if ({data_valid, checksum_err, timeout_err} !== 3'b000)
         $display("FAIL reset_pulses: got %b want 000",
                  {data_valid, checksum_err, timeout_err});
      else passed++;
   endtask

   task automatic test_known_frame();
      int d0, c0;
      d0 = dv_n;
      c0 = ck_n;
      set_widths(40'h3700190050, 1);
      send_frame(40);
      exp_out = {8'd55, 8'd0, 8'd25, 8'd0};
      total++;
      if (dv_n - d0 !== 1)
         $display("FAIL known_dv_count: got %0d want 1", dv_n - d0);
      else passed++;
      total++;
      if (ck_n - c0 !== 0)
         $display("FAIL known_ck_count: got %0d want 0", ck_n - c0);
      else passed++;
      total++;
      if (hum_int !== 8'd55)
         $display("FAIL known_hum_int: got %0d want 55", hum_int);
      else passed++;
      total++;
      if (temp_int !== 8'd25)
         $display("FAIL known_temp_int: got %0d want 25", temp_int);
      else passed++;
      total++;
      if ({hum_dec, temp_dec} !== 16'h0)
         $display("FAIL known_decimals: got %h want 0000", {hum_dec, temp_dec});
      else passed++;
      // 2 sync flops, then CHECK, then the registered pulse
      total++;
      if (dv_t - fall_t !== time'(4 * PERIOD))
         $display("FAIL known_latency: got %0t want %0t",
                  dv_t - fall_t, time'(4 * PERIOD));
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL known_busy: got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_bad_checksum();
      int d0, c0;
      d0 = dv_n;
      c0 = ck_n;
      set_widths(40'h3700190051, 1);
      send_frame(40);
      total++;
      if (ck_n - c0 !== 1)
         $display("FAIL bad_ck_count: got %0d want 1", ck_n - c0);
      else passed++;
      total++;
      if (dv_n - d0 !== 0)
         $display("FAIL bad_dv_count: got %0d want 0", dv_n - d0);
      else passed++;
      total++;
      if (outs() !== exp_out)
         $display("FAIL bad_outputs: got %h want %h", outs(), exp_out);
      else passed++;
   endtask

   task automatic run_checked_frame(input string tag);
      logic [39:0] w;
      bit good;
      int d0, c0, t0;
      d0 = dv_n;
      c0 = ck_n;
      t0 = to_n;
      w = model_word();
      good = model_good(w);
      if (good) exp_out = w[39:8];
      send_frame(40);
      total++;
      if (dv_n - d0 !== (good ? 1 : 0))
         $display("FAIL %s_dv: got %0d want %0d", tag, dv_n - d0, good ? 1 : 0);
      else passed++;
      total++;
      if (ck_n - c0 !== (good ? 0 : 1))
         $display("FAIL %s_ck: got %0d want %0d", tag, ck_n - c0, good ? 0 : 1);
      else passed++;
      total++;
      if (to_n - t0 !== 0)
         $display("FAIL %s_to: got %0d want 0", tag, to_n - t0);
      else passed++;
      total++;
      if (outs() !== exp_out)
         $display("FAIL %s_outputs: got %h want %h", tag, outs(), exp_out);
      else passed++;
   endtask

   task automatic test_threshold();
      set_widths(rand_frame(1'b0), 2);
      run_checked_frame("thresh");
   endtask

   task automatic test_random();
      for (int k = 0; k < 5; k++) begin
         set_widths(rand_frame($urandom_range(2) == 0), 0);
         run_checked_frame("random");
      end
   endtask

   task automatic test_timeout();
      int d0, c0, t0;
      d0 = dv_n;
      c0 = ck_n;
      t0 = to_n;
      set_widths(rand_frame(1'b0), 0);
      lows[10] = 130;
      send_frame(11);
      total++;
      if (to_n - t0 !== 1)
         $display("FAIL tmo_count: got %0d want 1", to_n - t0);
      else passed++;
      // 2 sync flops + entry into BIT_LOW + 121 counted us
      total++;
      if (to_t - low_t !== time'(124 * PERIOD))
         $display("FAIL tmo_time: got %0t want %0t",
                  to_t - low_t, time'(124 * PERIOD));
      else passed++;
      total++;
      if ((dv_n - d0) + (ck_n - c0) !== 0)
         $display("FAIL tmo_other_pulses: got %0d want 0",
                  (dv_n - d0) + (ck_n - c0));
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL tmo_busy: got %b want 0", busy);
      else passed++;
      total++;
      if (outs() !== exp_out)
         $display("FAIL tmo_outputs: got %h want %h", outs(), exp_out);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      int d0, c0, t0;
      d0 = dv_n;
      c0 = ck_n;
      t0 = to_n;
      set_widths(rand_frame(1'b0), 0);
      send_frame(20);
      rst = 1'b0;
      #1;
      exp_out = '0;
      total++;
      if (outs() !== 32'h0)
         $display("FAIL rstmid_bytes: got %h want 00000000", outs());
      else passed++;
      total++;
      if ({busy, data_valid, checksum_err, timeout_err} !== 4'b0)
         $display("FAIL rstmid_flags: got %b want 0000",
                  {busy, data_valid, checksum_err, timeout_err});
      else passed++;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 30);
      total++;
      if ((dv_n - d0) + (ck_n - c0) + (to_n - t0) !== 0)
         $display("FAIL rstmid_pulses: got %0d want 0",
                  (dv_n - d0) + (ck_n - c0) + (to_n - t0));
      else passed++;
      total++;
      if (busy !== 1'b0)
         $display("FAIL rstmid_no_restart: got busy %b want 0", busy);
      else passed++;
      set_widths(rand_frame(1'b0), 0);
      run_checked_frame("after_rst");
   endtask

   task automatic test_restart_ignored();
      restart_at = 15;
      set_widths(rand_frame(1'b0), 0);
      run_checked_frame("restart");
      restart_at = -1;
   endtask

   task automatic test_no_retrigger();
      int seen;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         dht_in = 1'b0;
         repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
         end
         dht_in = 1'b1;
         repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
         end
      end
      total++;
      if (seen !== 0)
         $display("FAIL level_start_retrigger: busy cycles %0d want 0", seen);
      else passed++;
   endtask

   task automatic test_exclusive();
      total++;
      if (excl_n !== 0)
         $display("FAIL pulse_exclusive: overlaps %0d want 0", excl_n);
      else passed++;
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      dht_in = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      test_known_frame();
      test_bad_checksum();
      test_threshold();
      test_random();
      test_timeout();
      test_reset_midframe();
      test_restart_ignored();
      test_no_retrigger();
      test_exclusive();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
